// File: rtl/gf_mul_seq.sv
// gf_mul_seq: digit-serial GF(2^WIDTH) multiplier, valid/ready on both sides.
// Optional multiply-accumulate (y = a*b ^ c) enabled by defining GF_MUL_MAC_EN.
module gf_mul_seq #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(8'h1B),
    parameter int                 DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef GF_MUL_MAC_EN
    input  logic [WIDTH-1:0] c,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_cnt;
`ifdef GF_MUL_MAC_EN
    logic [WIDTH-1:0] r_c;
`endif

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_y_nxt;

    // Multiply by x, folding the bit shifted out of m-1 back in via POLY.
    function automatic logic [WIDTH-1:0] f_xtime(input logic [WIDTH-1:0] v);
        f_xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    // Horner step over one digit: acc*x^DIGIT + a*d, reduced bit by bit.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] aop,
        input logic [DIGIT-1:0] d
    );
        logic [WIDTH-1:0] t;
        t = acc;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            t = f_xtime(t) ^ (d[i] ? aop : '0);
        end
        f_step = t;
    endfunction

    // Next accumulator from the current top digit of the multiplier.
    always_comb begin
        w_acc_nxt = f_step(r_acc, r_a, r_b[WIDTH-1 -: DIGIT]);
`ifdef GF_MUL_MAC_EN
        w_y_nxt   = w_acc_nxt ^ r_c;
`else
        w_y_nxt   = w_acc_nxt;
`endif
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
`ifdef GF_MUL_MAC_EN
            r_c         <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
`ifdef GF_MUL_MAC_EN
                        r_c        <= c;
`endif
                        r_acc      <= '0;
                        r_cnt      <= CW'(STEPS - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b << DIGIT;
                    if (r_cnt == '0) begin
                        r_y         <= w_y_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule

// File: tb/tb_gf_mul_seq.sv
// tb_gf_mul_seq: scoreboard bench for gf_mul_seq in three configurations.
// Directed AES vectors, hold/abort cases, exhaustive GF(16), single-cycle.
`timescale 1ns/1ps
module tb_gf_mul_seq;

    typedef struct {
        logic [31:0] exp;
        int          iss;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // main instance: WIDTH=8, POLY=1B, DIGIT=1
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] c = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;

    // GF(16) instance: WIDTH=4, POLY=3, DIGIT=2
    logic       v4_in = 1'b0;
    logic       r4_in;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic [3:0] c4 = '0;
    logic       v4_out;
    logic [3:0] y4;

    // single-cycle instance: WIDTH=DIGIT=8
    logic       vd_in = 1'b0;
    logic       rd_in;
    logic [7:0] ad = '0;
    logic [7:0] bd = '0;
    logic [7:0] cd = '0;
    logic       vd_out;
    logic [7:0] yd;

    item_t q_m[$];
    item_t q_4[$];
    item_t q_d[$];
    bit    seen_m = 1'b0;
    bit    rdy_chk = 1'b0;

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_m (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef GF_MUL_MAC_EN
        .c(c),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    gf_mul_seq #(.WIDTH(4), .POLY(4'h3), .DIGIT(2)) u_4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4_in), .in_ready(r4_in),
        .a(a4), .b(b4),
`ifdef GF_MUL_MAC_EN
        .c(c4),
`endif
        .out_valid(v4_out), .out_ready(1'b1), .y(y4)
    );

    gf_mul_seq #(.WIDTH(8), .POLY(8'h1B), .DIGIT(8)) u_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vd_in), .in_ready(rd_in),
        .a(ad), .b(bd),
`ifdef GF_MUL_MAC_EN
        .c(cd),
`endif
        .out_valid(vd_out), .out_ready(1'b1), .y(yd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // LSB-first shift-and-add reference for GF(16) with x^4+x+1.
    function automatic logic [3:0] gf16(input logic [3:0] x,
                                        input logic [3:0] m);
        logic [3:0] r;
        logic [3:0] t;
        r = '0;
        t = x;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = r ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    // main monitor: latency, result, hold stability, in_ready return
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_m = 1'b0;
            rdy_chk = 1'b0;
        end else begin
            if (rdy_chk) begin
                chk("in_ready_after_out", 32'(in_ready), 32'd1);
                rdy_chk = 1'b0;
            end
            if (out_valid) begin
                if (q_m.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!seen_m) begin
                        chk("latency_m", 32'(cyc - q_m[0].iss), 32'd8);
                        seen_m = 1'b1;
                    end
                    if (out_ready) begin
                        chk("y_m", 32'(y), q_m[0].exp);
                        void'(q_m.pop_front());
                        seen_m = 1'b0;
                        rdy_chk = 1'b1;
                    end else begin
                        chk("hold_y", 32'(y), q_m[0].exp);
                        chk("hold_in_ready", 32'(in_ready), 32'd0);
                    end
                end
            end
        end
    end

    // GF(16) monitor
    always @(negedge clk) begin
        if (rst_n && v4_out) begin
            if (q_4.size() == 0) begin
                chk("unexpected_v4", 32'(v4_out), 32'd0);
            end else begin
                chk("latency_4", 32'(cyc - q_4[0].iss), 32'd2);
                chk("y_4", 32'(y4), q_4[0].exp);
                void'(q_4.pop_front());
            end
        end
    end

    // single-cycle monitor
    always @(negedge clk) begin
        if (rst_n && vd_out) begin
            if (q_d.size() == 0) begin
                chk("unexpected_vd", 32'(vd_out), 32'd0);
            end else begin
                chk("latency_d", 32'(cyc - q_d[0].iss), 32'd1);
                chk("y_d", 32'(yd), q_d[0].exp);
                void'(q_d.pop_front());
            end
        end
    end

    task automatic issue_m(input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ic, input logic [7:0] ie);
        int n;
        n = 0;
        a = ia;
        b = ib;
        c = ic;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_handshake_timeout_m", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        q_m.push_back('{exp: 32'(ie), iss: cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_4(input logic [3:0] ia, input logic [3:0] ib,
                           input logic [3:0] ie);
        int n;
        n = 0;
        a4 = ia;
        b4 = ib;
        v4_in = 1'b1;
        while (!r4_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!r4_in) begin
            chk("in_handshake_timeout_4", 32'd0, 32'd1);
            v4_in = 1'b0;
            return;
        end
        q_4.push_back('{exp: 32'(ie), iss: cyc + 1});
        @(posedge clk);
        #1 v4_in = 1'b0;
    endtask

    task automatic issue_d(input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ie);
        int n;
        n = 0;
        ad = ia;
        bd = ib;
        vd_in = 1'b1;
        while (!rd_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rd_in) begin
            chk("in_handshake_timeout_d", 32'd0, 32'd1);
            vd_in = 1'b0;
            return;
        end
        q_d.push_back('{exp: 32'(ie), iss: cyc + 1});
        @(posedge clk);
        #1 vd_in = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q_m.size() != 0 || out_valid || q_4.size() != 0 || v4_out ||
                q_d.size() != 0 || vd_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(q_m.size() + q_4.size() + q_d.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        issue_m(8'h57, 8'h83, 8'h00, 8'hC1);
        drain("drain_basic");
        issue_m(8'h57, 8'h01, 8'h00, 8'h57);
        issue_m(8'h00, 8'h83, 8'h00, 8'h00);
        issue_m(8'h80, 8'h02, 8'h00, 8'h1B);
        issue_m(8'hFF, 8'hFF, 8'h00, 8'h13);
        drain("drain_bounds");

        out_ready = 1'b0;
        issue_m(8'h57, 8'h13, 8'h00, 8'hFE);
        a = 8'hAA;
        b = 8'h55;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("hold_reached_done", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        issue_m(8'hFF, 8'h00, 8'h00, 8'h00);
        drain("drain_hold");

`ifdef GF_MUL_MAC_EN
        issue_m(8'h57, 8'h83, 8'hC1, 8'h00);
        issue_m(8'h57, 8'h83, 8'hFF, 8'h3E);
        drain("drain_mac");
`endif

        issue_m(8'h57, 8'h13, 8'h00, 8'hFE);
        drain("drain_pre_abort");
        issue_m(8'h57, 8'h83, 8'h00, 8'hC1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        q_m.delete();
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        issue_m(8'h57, 8'h83, 8'h00, 8'hC1);
        drain("drain_after_abort");

        issue_4(4'h2, 4'h9, 4'h1);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                issue_4(4'(i), 4'(j), gf16(4'(i), 4'(j)));
            end
        end
        drain("drain_gf16");

        issue_d(8'h02, 8'h80, 8'h1B);
        issue_d(8'h57, 8'h83, 8'hC1);
        issue_d(8'h57, 8'h13, 8'hFE);
        drain("drain_single");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_mul_seq.md
Name: gf_mul_seq

Overview:
Parametrised digit-serial GF(2^WIDTH) multiplier with a valid/ready handshake on both sides.
- Generalises the fixed 4-bit combinational composite-field multiplier core to any field width, any reduction polynomial and a configurable digit size per cycle.
- Used in the AES datapath and in GF(2^8)/GF(2^4) utility blocks where area matters more than throughput.

Parameters:
WIDTH, 8, field degree m; operands and result are m bits; legal range 2..32
POLY, 8'h1B, low m bits of the irreducible polynomial; the x^m term is implicit (AES default: x^8+x^4+x^3+x+1)
DIGIT, 1, bits of operand b consumed per cycle; must divide WIDTH; DIGIT=WIDTH gives single-cycle compute

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b present
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier, consumed MSB-first
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
y  output  WIDTH  product a*b mod P

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - All registers clear immediately on rst_n=0: state=IDLE, acc=0, y=0, out_valid=0, digit counter=0.
  - in_ready=0 while rst_n=0 and becomes 1 in IDLE after release.
- FSM states:
  - IDLE: in_ready=1.
    - On in_valid&in_ready: latch a into a_r and b into b_r, clear acc, load cnt=WIDTH/DIGIT-1, go to BUSY.
  - BUSY: in_ready=0, in_valid ignored. Each cycle:
    - acc <= (acc * x^DIGIT mod P) XOR (a_r * d mod P), where d = top DIGIT bits of b_r.
    - b_r shifts left by DIGIT.
    - Reduction is applied bit-by-bit: each shift step XORs POLY into the value when the bit shifted out of position m-1 is 1.
    - When cnt=0: y <= next acc value, out_valid <= 1, go to DONE. Otherwise cnt decrements.
  - DONE: out_valid=1 and y held stable until out_ready=1.
    - On out_valid&out_ready: out_valid <= 0, go to IDLE.
    - in_ready=0 in DONE, so there is no same-cycle back-to-back acceptance.
- Latency: in-handshake at edge N gives out_valid=1 after edge N+WIDTH/DIGIT.
  - Throughput: one result per WIDTH/DIGIT+2 cycles when out_ready is held high.
- Arithmetic: all addition is XOR; no carries; result is always fully reduced (< 2^WIDTH).
- Boundary conditions:
  - a=0 or b=0 → y=0.
  - b=1 → y=a.
  - Operand with MSB set triggers reduction on the first shift step.
  - out_ready held low indefinitely → y and out_valid stable; no input accepted.
  - in_valid asserted during BUSY/DONE → no effect, operands not sampled.
  - rst_n asserted mid-BUSY → operation aborted, no out_valid pulse after release.
- y only changes on the BUSY→DONE transition or on reset.

Optional Feature:
GF_MUL_MAC_EN
- Defined:
  - Adds port c (input, WIDTH), latched with a/b on the in-handshake.
  - Result is y = (a*b mod P) XOR c_r; the XOR is applied on the BUSY→DONE load, with no extra latency.
  - Reset clears c_r.
- Undefined: port c does not exist; y = a*b mod P.

Test Plan:
- WIDTH=8, POLY=8'h1B, DIGIT=1; a=8'h57, b=8'h83, out_ready=1 → out_valid exactly 8 cycles after handshake, y=8'hC1, then in_ready=1 one cycle after out-handshake.
- Same config; a=8'h57, b=8'h13, then a=8'hFF, b=8'h00 → y=8'hFE, then y=8'h00. Hold out_ready=0 for 5 cycles on the first result → y/out_valid stable, in_ready=0 throughout.
- WIDTH=4, POLY=4'h3, DIGIT=2; a=4'h2, b=4'h9 → y=4'h1 after 2 cycles. Exhaustive 256 pairs against a software GF(16) model → all match.
- DIGIT=WIDTH=8: a=8'h02, b=8'h80 → y=8'h1B one cycle after handshake.
- rst_n pulsed low mid-BUSY (cycle 3 of 8) → out_valid, y, in_ready drop to 0 asynchronously; no result appears after release; the next operation computes correctly.
- GF_MUL_MAC_EN defined: a=8'h57, b=8'h83, c=8'hC1 → y=8'h00; c=8'hFF → y=8'h3E.
